// File: rtl/spi_note_receiver.sv
`timescale 1ns/1ps
// spi_note_receiver
// Mode-0 SPI slave that collects 56-bit note on/off frames from the host MCU
// and presents them on the command bus consumed by voice_controller.
// Frame layout, MSB first, cs_n low throughout:
//   cmd[7:0] | voice_index[7:0] | velocity[7:0] | tuning_code[31:0]
//
// Handshake: o_SPI_flag is a one-cycle valid strobe with no ready. The four
// o_SPI_* fields change only in the cycle o_SPI_flag is high and then hold
// until the next accepted frame. o_frame_error is a one-cycle strobe for a
// rejected frame and is never high together with o_SPI_flag.
//
// i_reset must be released synchronously to i_clk; its assertion may be
// asynchronous. SYNC_STAGES must be at least 2.
module spi_note_receiver #(
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_VOICES  = 256,
  parameter logic [7:0] CMD_ON      = 8'h90,
  parameter logic [7:0] CMD_OFF     = 8'h80
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_spi_sclk,
  input  logic        i_spi_cs_n,
  input  logic        i_spi_mosi,
  output logic        o_SPI_flag,
  output logic        o_SPI_note_status,
  output logic [7:0]  o_SPI_voice_index,
  output logic [7:0]  o_SPI_velocity,
  output logic [31:0] o_SPI_tuning_code,
  output logic        o_frame_error,
  output logic [1:0]  o_dbg_state
);

  localparam logic [5:0]  FRAME_BITS   = 6'd56;
  localparam logic [31:0] NUM_VOICES_W = 32'(NUM_VOICES);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2,
    CHECK     = 2'd3
  } state_t;

  // Synchronizer chains; index SYNC_STAGES-1 is the synchronized value.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_n_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_n_prev_q;

  // Fills with ones after reset; once full, the chains hold real pin samples
  // rather than their reset values.
  logic [SYNC_STAGES:0]   warm_q;

  state_t      state_q;
  logic [55:0] shift_q;
  logic [5:0]  count_q;

  logic        sclk_sync;
  logic        cs_n_sync;
  logic        mosi_sync;
  logic        sclk_rise;
  logic        cs_n_rise;
  logic        warm_done;

  logic [7:0]  frame_cmd;
  logic [7:0]  frame_index;
  logic [7:0]  frame_velocity;
  logic [31:0] frame_tuning;
  logic [31:0] frame_index_w;
  logic        cmd_ok;
  logic        index_ok;
  logic        frame_ok;

  assign sclk_sync = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_sync = cs_n_sync_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync & ~sclk_prev_q;
  assign cs_n_rise = cs_n_sync & ~cs_n_prev_q;
  assign warm_done = warm_q[SYNC_STAGES];

  assign frame_cmd      = shift_q[55:48];
  assign frame_index    = shift_q[47:40];
  assign frame_velocity = shift_q[39:32];
  assign frame_tuning   = shift_q[31:0];
  assign frame_index_w  = {24'd0, frame_index};

  assign cmd_ok   = (frame_cmd == CMD_ON) || (frame_cmd == CMD_OFF);
  assign index_ok = frame_index_w < NUM_VOICES_W;
  assign frame_ok = (count_q == FRAME_BITS) && cmd_ok && index_ok;

  assign o_dbg_state = state_q;

  // Bring the three SPI pins into the i_clk domain; cs_n idles deselected.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_sync_q <= '0;
      cs_n_sync_q <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
    end
  end

  // One extra flop per edge-detected signal for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_sync;
      cs_n_prev_q <= cs_n_sync;
    end
  end

  // Post-reset settle timer so WAIT_IDLE never trusts the reset value of cs_n.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      warm_q <= '0;
    end else begin
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame FSM with shift register, saturating bit counter and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q           <= WAIT_IDLE;
      shift_q           <= '0;
      count_q           <= '0;
      o_SPI_flag        <= 1'b0;
      o_SPI_note_status <= 1'b0;
      o_SPI_voice_index <= '0;
      o_SPI_velocity    <= '0;
      o_SPI_tuning_code <= '0;
      o_frame_error     <= 1'b0;
    end else begin
      o_SPI_flag    <= 1'b0;
      o_frame_error <= 1'b0;
      case (state_q)
        // A frame already running when reset released is dropped silently.
        WAIT_IDLE: begin
          if (warm_done && cs_n_sync) begin
            state_q <= IDLE;
          end
        end
        // Level check also catches a select that fell while we were in CHECK.
        IDLE: begin
          if (!cs_n_sync) begin
            shift_q <= '0;
            count_q <= '0;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (cs_n_rise) begin
            state_q <= CHECK;
          end else if (sclk_rise && !cs_n_sync && (count_q != FRAME_BITS)) begin
            shift_q <= {shift_q[54:0], mosi_sync};
            count_q <= count_q + 6'd1;
          end
        end
        CHECK: begin
          if (frame_ok) begin
            o_SPI_flag        <= 1'b1;
            o_SPI_note_status <= (frame_cmd == CMD_ON);
            o_SPI_voice_index <= frame_index;
            o_SPI_velocity    <= frame_velocity;
            o_SPI_tuning_code <= frame_tuning;
          end else begin
            o_frame_error <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= WAIT_IDLE;
        end
      endcase
    end
  end

endmodule
